// File: rtl/uib_arbiter.sv
// uib_arbiter: two-master to one-slave UIB arbiter in front of main memory.
// Master 0 is instruction fetch and master 1 is load/store.
// The grant path is combinational. Read data returns exactly one cycle after
// the grant and is steered back to the master that issued the read.
module uib_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 32,
  parameter int MW         = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_wen,
  input  logic [AW-1:0]   m0_addr,
  input  logic [MW-1:0]   m0_mode,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_wen,
  input  logic [AW-1:0]   m1_addr,
  input  logic [MW-1:0]   m1_mode,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            bus_req,
  output logic            bus_wen,
  output logic [AW-1:0]   bus_addr,
  output logic [MW-1:0]   bus_mode,
  output logic [XLEN-1:0] bus_dat_i,
  input  logic [XLEN-1:0] bus_dat_o
);

  typedef enum logic [1:0] {IDLE, RD0, RD1} owner_t;

  owner_t owner, owner_nxt;
  logic   last_gnt;   // 1 = master 1 won most recently
  logic   sel1;

  // Arbitration: under contention, fixed priority favours m0 and round-robin
  // favours the master that did not win last time.
  always_comb begin
    sel1 = 1'b0;
    if (m0_req && m1_req)
      sel1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
    else
      sel1 = m1_req;
    bus_req = ~rst & (m0_req | m1_req);
    m0_gnt  = ~rst & m0_req & ~sel1;
    m1_gnt  = ~rst & m1_req &  sel1;
  end

  // Request fields are taken from the granted master, and are zero when no master is granted.
  always_comb begin
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_mode  = '0;
    bus_dat_i = '0;
    if (m0_gnt) begin
      bus_wen   = m0_wen;
      bus_addr  = m0_addr;
      bus_mode  = m0_mode;
      bus_dat_i = m0_wdata;
    end else if (m1_gnt) begin
      bus_wen   = m1_wen;
      bus_addr  = m1_addr;
      bus_mode  = m1_mode;
      bus_dat_i = m1_wdata;
    end
  end

  // Round-robin history. It advances only when a master is actually granted.
  always_ff @(posedge clk) begin
    if (rst)
      last_gnt <= 1'b1;
    else if (bus_req)
      last_gnt <= m1_gnt;
  end

  // Owner register: records which master's read returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) owner <= IDLE;
    else     owner <= owner_nxt;
  end

  // Next owner. Only a granted read creates an outstanding response.
  always_comb begin
    owner_nxt = IDLE;
    if (m0_gnt && !m0_wen)      owner_nxt = RD0;
    else if (m1_gnt && !m1_wen) owner_nxt = RD1;
  end

  // Read return steering. Read data is zero toward a master that has no response due.
  always_comb begin
    m0_rvalid = (owner == RD0);
    m1_rvalid = (owner == RD1);
    m0_rdata  = m0_rvalid ? bus_dat_o : '0;
    m1_rdata  = m1_rvalid ? bus_dat_o : '0;
  end

endmodule

// File: tb/tb_uib_arbiter.sv
// Directed vector bench for uib_arbiter. The bench uses a round-robin instance and a fixed-priority instance.
// Both instances share the same inputs. Inputs are driven 1ns after posedge and outputs are sampled 7ns after posedge.
module tb_uib_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_dat_o;
  logic [1:0]  m0_mode, m1_mode;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_req, bus_wen;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_dat_i;
  logic [1:0]  bus_mode;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_bus_req, fp_bus_wen;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_bus_addr, fp_bus_dat_i;
  logic [1:0]  fp_bus_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uib_arbiter #(.XLEN(32), .AW(32), .MW(2), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_mode(m0_mode), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_mode(m1_mode), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_mode(bus_mode),
    .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o));

  uib_arbiter #(.XLEN(32), .AW(32), .MW(2), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_mode(m0_mode), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_mode(m1_mode), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .bus_req(fp_bus_req), .bus_wen(fp_bus_wen), .bus_addr(fp_bus_addr), .bus_mode(fp_bus_mode),
    .bus_dat_i(fp_bus_dat_i), .bus_dat_o(bus_dat_o));

  typedef struct {
    string       name;
    logic        rst;
    logic        r0, w0; logic [31:0] a0; logic [1:0] md0; logic [31:0] d0;
    logic        r1, w1; logic [31:0] a1; logic [1:0] md1; logic [31:0] d1;
    logic [31:0] dato;
    logic        breq, g0, g1, bwen; logic [31:0] baddr; logic [1:0] bmode; logic [31:0] bdat;
    logic        rv0; logic [31:0] rd0; logic rv1; logic [31:0] rd1;
    logic        fg0, fg1;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q0, input logic e0, input logic [31:0] a0,
                       input logic [1:0] md0, input logic [31:0] d0,
                       input logic q1, input logic e1, input logic [31:0] a1,
                       input logic [1:0] md1, input logic [31:0] d1, input logic [31:0] dato);
    @(posedge clk); #1;
    rst = r;
    m0_req = q0; m0_wen = e0; m0_addr = a0; m0_mode = md0; m0_wdata = d0;
    m1_req = q1; m1_wen = e1; m1_addr = a1; m1_mode = md1; m1_wdata = d1;
    bus_dat_o = dato;
    #6;
  endtask

  function automatic vec_t mk(string n, logic r,
      logic r0, logic w0, logic [31:0] a0, logic [1:0] md0, logic [31:0] d0,
      logic r1, logic w1, logic [31:0] a1, logic [1:0] md1, logic [31:0] d1, logic [31:0] dato,
      logic breq, logic g0, logic g1, logic bwen, logic [31:0] baddr, logic [1:0] bmode,
      logic [31:0] bdat, logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1,
      logic fg0, logic fg1);
    vec_t v;
    v.name = n; v.rst = r;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.md0 = md0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.md1 = md1; v.d1 = d1; v.dato = dato;
    v.breq = breq; v.g0 = g0; v.g1 = g1; v.bwen = bwen; v.baddr = baddr; v.bmode = bmode;
    v.bdat = bdat; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1; v.fg0 = fg0; v.fg1 = fg1;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wen = 0; m0_addr = 0; m0_mode = 0; m0_wdata = 0;
    m1_req = 0; m1_wen = 0; m1_addr = 0; m1_mode = 0; m1_wdata = 0;
    bus_dat_o = 0;
    repeat (2) @(posedge clk);

    //          name        rst r0 w0 a0     md d0            r1 w1 a1     md d1            dato
    //          breq g0 g1 wen addr   md bdat          rv0 rd0           rv1 rd1           fg0 fg1
    tbl.push_back(mk("rst_read",  1, 1,0,32'h100,2,0,           0,0,0,0,0,                  0,
                     0,0,0,0,0,0,0,                 0,0,            0,0,            0,0));
    tbl.push_back(mk("idle",      0, 0,0,0,0,0,                 0,0,0,0,0,                  32'h5A5A,
                     0,0,0,0,0,0,0,                 0,0,            0,0,            0,0));
    tbl.push_back(mk("cont1",     0, 1,0,32'h200,1,0,           1,0,32'h300,3,0,            0,
                     1,1,0,0,32'h200,1,0,           0,0,            0,0,            1,0));
    tbl.push_back(mk("cont2",     0, 1,0,32'h200,1,0,           1,0,32'h300,3,0,            32'hA0,
                     1,0,1,0,32'h300,3,0,           1,32'hA0,       0,0,            1,0));
    tbl.push_back(mk("cont3",     0, 1,0,32'h200,1,0,           1,0,32'h300,3,0,            32'hA1,
                     1,1,0,0,32'h200,1,0,           0,0,            1,32'hA1,       1,0));
    tbl.push_back(mk("cont4",     0, 1,0,32'h200,1,0,           1,0,32'h300,3,0,            32'hA2,
                     1,0,1,0,32'h300,3,0,           1,32'hA2,       0,0,            1,0));
    tbl.push_back(mk("cont_tail", 0, 0,0,0,0,0,                 0,0,0,0,0,                  32'hA3,
                     0,0,0,0,0,0,0,                 0,0,            1,32'hA3,       0,0));
    tbl.push_back(mk("rd_m0",     0, 1,0,32'h100,2,0,           0,0,0,0,0,                  0,
                     1,1,0,0,32'h100,2,0,           0,0,            0,0,            1,0));
    tbl.push_back(mk("rd_m0_ret", 0, 0,0,0,0,0,                 0,0,0,0,0,                  32'hDEADBEEF,
                     0,0,0,0,0,0,0,                 1,32'hDEADBEEF, 0,0,            0,0));
    tbl.push_back(mk("wr_m1",     0, 0,0,0,0,0,                 1,1,32'h40,0,32'h12345678,  0,
                     1,0,1,1,32'h40,0,32'h12345678, 0,0,            0,0,            0,1));
    tbl.push_back(mk("rd_m1",     0, 0,0,0,0,0,                 1,0,32'h40,0,0,             32'h55,
                     1,0,1,0,32'h40,0,0,            0,0,            0,0,            0,1));
    tbl.push_back(mk("rd_m1_ret", 0, 0,0,0,0,0,                 0,0,0,0,0,                  32'h12345678,
                     0,0,0,0,0,0,0,                 0,0,            1,32'h12345678, 0,0));
    tbl.push_back(mk("il_m0",     0, 1,0,32'h0,0,0,             0,0,0,0,0,                  0,
                     1,1,0,0,32'h0,0,0,             0,0,            0,0,            1,0));
    tbl.push_back(mk("il_m1",     0, 0,0,0,0,0,                 1,0,32'h4,0,0,              32'hCAFE0000,
                     1,0,1,0,32'h4,0,0,             1,32'hCAFE0000, 0,0,            0,1));
    tbl.push_back(mk("il_tail",   0, 0,0,0,0,0,                 0,0,0,0,0,                  32'hBEEF0004,
                     0,0,0,0,0,0,0,                 0,0,            1,32'hBEEF0004, 0,0));
    tbl.push_back(mk("mr_rd",     0, 1,0,32'h8,0,0,             0,0,0,0,0,                  0,
                     1,1,0,0,32'h8,0,0,             0,0,            0,0,            1,0));
    tbl.push_back(mk("mr_rst",    1, 0,0,0,0,0,                 0,0,0,0,0,                  32'h777,
                     0,0,0,0,0,0,0,                 1,32'h777,      0,0,            0,0));
    tbl.push_back(mk("mr_after",  0, 0,0,0,0,0,                 0,0,0,0,0,                  32'h999,
                     0,0,0,0,0,0,0,                 0,0,            0,0,            0,0));
    tbl.push_back(mk("mr_cont",   0, 1,0,32'h10,1,0,            1,0,32'h14,3,0,             0,
                     1,1,0,0,32'h10,1,0,            0,0,            0,0,            1,0));
    tbl.push_back(mk("mr_ret",    0, 0,0,0,0,0,                 0,0,0,0,0,                  32'h1,
                     0,0,0,0,0,0,0,                 1,32'h1,        0,0,            0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].md0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].md1, tbl[i].d1, tbl[i].dato);
      check({tbl[i].name, ".bus_req"},   {31'd0, bus_req},   {31'd0, tbl[i].breq});
      check({tbl[i].name, ".m0_gnt"},    {31'd0, m0_gnt},    {31'd0, tbl[i].g0});
      check({tbl[i].name, ".m1_gnt"},    {31'd0, m1_gnt},    {31'd0, tbl[i].g1});
      check({tbl[i].name, ".bus_wen"},   {31'd0, bus_wen},   {31'd0, tbl[i].bwen});
      check({tbl[i].name, ".bus_addr"},  bus_addr,           tbl[i].baddr);
      check({tbl[i].name, ".bus_mode"},  {30'd0, bus_mode},  {30'd0, tbl[i].bmode});
      check({tbl[i].name, ".bus_dat_i"}, bus_dat_i,          tbl[i].bdat);
      check({tbl[i].name, ".m0_rvalid"}, {31'd0, m0_rvalid}, {31'd0, tbl[i].rv0});
      check({tbl[i].name, ".m0_rdata"},  m0_rdata,           tbl[i].rd0);
      check({tbl[i].name, ".m1_rvalid"}, {31'd0, m1_rvalid}, {31'd0, tbl[i].rv1});
      check({tbl[i].name, ".m1_rdata"},  m1_rdata,           tbl[i].rd1);
      check({tbl[i].name, ".fp_bus_req"},{31'd0, fp_bus_req},{31'd0, tbl[i].breq});
      check({tbl[i].name, ".fp_m0_gnt"}, {31'd0, fp_m0_gnt}, {31'd0, tbl[i].fg0});
      check({tbl[i].name, ".fp_m1_gnt"}, {31'd0, fp_m1_gnt}, {31'd0, tbl[i].fg1});
    end

    // Fixed priority under sustained contention: m0 wins every cycle, and its
    // reads return one cycle later. Read data is zero toward m1.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1,0,32'h20,1,0, 1,0,32'h24,2,0, 32'h100 + k);
      check("fp_cont.m0_gnt",   {31'd0, fp_m0_gnt}, 32'd1);
      check("fp_cont.m1_gnt",   {31'd0, fp_m1_gnt}, 32'd0);
      check("fp_cont.bus_addr", fp_bus_addr, 32'h20);
      check("fp_cont.bus_mode", {30'd0, fp_bus_mode}, 32'd1);
      check("fp_cont.m0_rvalid",{31'd0, fp_m0_rvalid}, (k == 0) ? 32'd0 : 32'd1);
      check("fp_cont.m0_rdata", fp_m0_rdata, (k == 0) ? 32'd0 : 32'h100 + k);
      check("fp_cont.m1_rvalid",{31'd0, fp_m1_rvalid}, 32'd0);
      check("fp_cont.m1_rdata", fp_m1_rdata, 32'd0);
    end

    // Contended writes never produce an rvalid, regardless of which master wins.
    drive(0, 1,1,32'h30,0,32'hAA, 1,1,32'h34,0,32'hBB, 32'h200);
    check("fp_wr.bus_wen",   {31'd0, fp_bus_wen}, 32'd1);
    check("fp_wr.bus_dat_i", fp_bus_dat_i, 32'hAA);
    check("wr_cont.bus_wen", {31'd0, bus_wen}, 32'd1);
    drive(0, 0,0,0,0,0, 0,0,0,0,0, 32'h300);
    check("wr_ret.m0_rvalid",    {31'd0, m0_rvalid},    32'd0);
    check("wr_ret.m1_rvalid",    {31'd0, m1_rvalid},    32'd0);
    check("wr_ret.fp_m0_rvalid", {31'd0, fp_m0_rvalid}, 32'd0);
    check("wr_ret.m0_rdata",     m0_rdata,              32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uib_arbiter.md
Name: uib_arbiter

Overview:
- Two-master to one-slave arbiter on the UIB bus. It sits directly upstream of the main memory slave.
- Master 0 is the instruction-fetch port; master 1 is the load/store port.
- Each cycle it forwards at most one request to the slave. It routes the slave's fixed one-cycle read data back to the master that issued the read.

Parameters:
- XLEN, 32, data width of the bus
- AW, 32, address width of the bus
- MW, 2, width of the bus access-mode field; passed through to the slave untouched
- FIXED_PRIO, 0, arbitration policy: 0 = round-robin on contention, 1 = master 0 always wins

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 request, held until granted
- m0_wen  in  1  master 0 write enable
- m0_addr  in  AW  master 0 byte address
- m0_mode  in  MW  master 0 access mode
- m0_wdata  in  XLEN  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  XLEN  master 0 read data
- m1_req, m1_wen, m1_addr, m1_mode, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the master 0 ports, for master 1
- bus_req  out  1  request to slave
- bus_wen  out  1  write enable to slave
- bus_addr  out  AW  address to slave
- bus_mode  out  MW  mode to slave
- bus_dat_i  out  XLEN  write data to slave
- bus_dat_o  in  XLEN  read data from slave, valid one cycle after bus_req; zero when the slave was not enabled

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous, active-high.
- Grant path is combinational:
  - bus_req = m0_req | m1_req.
  - Exactly one mN_gnt is high in any cycle where bus_req is high; both are low when bus_req is low.
  - The bus_wen, bus_addr, bus_mode and bus_dat_i fields are muxed from the granted master in the same cycle.
  - When no master requests, these fields are driven to 0.
- Arbitration:
  - Single requester: that requester is granted.
  - Both request, FIXED_PRIO=1: master 0 is granted.
  - Both request, FIXED_PRIO=0: the master that was NOT granted most recently wins. Register last_gnt records the most recent winner; it updates only on cycles with bus_req high.
  - A master that loses keeps its request asserted and is served next cycle under round-robin. Its request fields must be held stable until its gnt.
- Response tracking:
  - Registered owner state, one of three: IDLE, RD0 (a master 0 read is outstanding) or RD1 (a master 1 read is outstanding).
  - On each clk edge owner becomes RD0 if the cycle granted a master 0 read (m0_gnt & ~m0_wen), RD1 if it granted a master 1 read, else IDLE.
  - Writes never produce rvalid.
- Read return:
  - mN_rvalid = (owner == RDN), i.e. one cycle after the granted read.
  - mN_rdata = bus_dat_o when mN_rvalid, else 0.
  - Read latency is therefore exactly 1 cycle from gnt.
  - Back-to-back reads, alternating or same master, sustain one transaction per cycle. A grant and a return for different masters may occur in the same cycle.
- Reset:
  - Owner goes to IDLE; all rvalid and rdata outputs are 0 the cycle after rst.
  - last_gnt resets to master 1, so master 0 wins the first contended cycle.
  - A read granted in the cycle rst is high is discarded: no rvalid follows.
  - gnt outputs are combinational. While rst is high, gnt and bus_req are forced to 0.
- No internal buffering: the slave is always ready, so there is no backpressure beyond arbitration.

Test Plan:
- Idle after reset: rst high 2 cycles, no requests -> bus_req=0, gnt=0, rvalid=0, rdata=0, bus fields=0.
- Single read: m0 read addr 0x100, mode 2, one cycle -> same cycle m0_gnt=1, bus_addr=0x100, bus_mode=2, bus_wen=0. Next cycle slave returns 0xDEADBEEF -> m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0, m1_rdata=0.
- Contention, round-robin: both masters hold read requests 4 cycles, FIXED_PRIO=0 -> grants go m0, m1, m0, m1, and each rvalid follows its grant by one cycle. With FIXED_PRIO=1 -> m0 granted all 4 cycles, m1_gnt=0.
- Write then read: m1 writes 0x12345678 to 0x40, then m1 reads 0x40 -> write cycle: m1_gnt=1, bus_wen=1, bus_dat_i=0x12345678, and no rvalid the next cycle. Read: m1_rvalid=1 one cycle later, with rdata passed from bus_dat_o.
- Interleaved: m0 reads 0x0 in cycle N while m1 reads 0x4 in cycle N+1 -> cycle N+1: m0_rvalid=1 and m1_gnt=1. Cycle N+2: m1_rvalid=1, m0_rvalid=0.
- Reset mid-read: m0 read granted in cycle N, rst asserted in cycle N+1 -> m0_rvalid=0 in cycle N+2. After rst falls, a contended request grants m0 first.
